// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage and its command FIFO:
//   - opcode encodings understood by the combinational ALU (OP_ADD..OP_INC)
//   - OP_LAST, the highest legal opcode; anything above it is illegal
//   - issue FSM state encoding (IDLE=0, EXEC=1, DONE=2)
//   - op_is_illegal(): opcode legality helper
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_INC  = 4'd10;
  localparam logic [3:0] OP_LAST = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } issue_state_t;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op > OP_LAST);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_if
// Bundles the three handshakes around the ALU issue stage:
//   cmd_*  producer -> stage command channel (valid/ready)
//   alu_*  stage -> ALU registered operands, alu_result ALU -> stage
//   res_*  stage -> consumer result channel (valid/ready) plus res_err
// Modports:
//   slave  : the issue stage itself
//   master : the environment (producer, ALU and consumer side)
// -----------------------------------------------------------------------------
interface alu_issue_stage_if #(
  parameter int WIDTH     = 8,
  parameter int MUL_WIDTH = 12
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [WIDTH-1:0]     cmd_a;
  logic [WIDTH-1:0]     cmd_b;
  logic [3:0]           cmd_opsel;

  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [3:0]           alu_opsel;
  logic [MUL_WIDTH-1:0] alu_result;

  logic                 res_valid;
  logic                 res_ready;
  logic [MUL_WIDTH-1:0] res_data;
  logic                 res_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_opsel, alu_result, res_ready,
    output cmd_ready, alu_a, alu_b, alu_opsel, res_valid, res_data, res_err
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_opsel, alu_result, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_opsel, res_valid, res_data, res_err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous command FIFO, DEPTH entries of ENTRY_W bits (power-of-2 DEPTH).
// Ports:
//   CLK      clock, rising edge
//   RST      asynchronous active-low reset (empties the FIFO)
//   push     write wr_data (ignored while full)
//   pop      advance read pointer (ignored while empty)
//   wr_data  entry to write
//   rd_data  current head entry (valid while !empty)
//   full     count == DEPTH
//   empty    count == 0
// Storage is not reset; only pointers and occupancy are.
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
  parameter int ENTRY_W = 20,
  parameter int DEPTH   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Buffers ALU commands in a small FIFO, issues them one at a time through
// registered operands, captures the ALU result and offers it downstream.
// Illegal opcodes and divide-by-zero are caught here and reported on res_err
// with res_data forced to zero.
// Ports:
//   CLK   clock, rising edge
//   RST   asynchronous active-low reset
//   bus   alu_issue_stage_if.slave: cmd_* in, alu_* out / alu_result in,
//         res_* out with res_ready in
// Optional (macro ALU_ISSUE_OPCNT_EN):
//   op_count  [15:0] saturating count of executed commands
//   err_count [7:0]  saturating count of executed commands flagged as errors
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MUL_WIDTH = 12,
  parameter int DEPTH     = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  alu_issue_stage_if.slave     bus
`ifdef ALU_ISSUE_OPCNT_EN
  ,
  output logic [15:0]          op_count,
  output logic [7:0]           err_count
`endif
);

  localparam int ENTRY_W = 2 * WIDTH + 4;

  issue_state_t         state_q;
  issue_state_t         state_d;
  logic                 pop;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head_entry;

  logic [WIDTH-1:0]     alu_a_p0;
  logic [WIDTH-1:0]     alu_b_p0;
  logic [3:0]           alu_opsel_p0;
  logic                 vld_p1;
  logic [MUL_WIDTH-1:0] res_data_p1;
  logic                 res_err_p1;
  logic                 exec_err;

  // cmd_ready comes straight from registered occupancy, never from res_ready.
  assign push          = bus.cmd_valid & ~fifo_full;
  assign bus.cmd_ready = ~fifo_full;
  assign push_entry    = {bus.cmd_opsel, bus.cmd_a, bus.cmd_b};

  alu_cmd_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = DONE;
      DONE: begin
        // Result handed off: chain straight into the next command if one waits.
        if (bus.res_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign exec_err = op_is_illegal(alu_opsel_p0) ||
                    ((alu_opsel_p0 == OP_DIV) && (alu_b_p0 == '0));

  // Issue stage: operands held until the next pop, so the ALU inputs never glitch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_a_p0     <= '0;
      alu_b_p0     <= '0;
      alu_opsel_p0 <= '0;
    end else if (pop) begin
      {alu_opsel_p0, alu_a_p0, alu_b_p0} <= head_entry;
    end
  end

  // Result stage: captured only in EXEC, held through DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_p1      <= 1'b0;
      res_data_p1 <= '0;
      res_err_p1  <= 1'b0;
    end else if (state_q == EXEC) begin
      vld_p1      <= 1'b1;
      res_data_p1 <= exec_err ? '0 : bus.alu_result;
      res_err_p1  <= exec_err;
    end else if ((state_q == DONE) && bus.res_ready) begin
      vld_p1      <= 1'b0;
    end
  end

  assign bus.alu_a     = alu_a_p0;
  assign bus.alu_b     = alu_b_p0;
  assign bus.alu_opsel = alu_opsel_p0;
  assign bus.res_valid = vld_p1;
  assign bus.res_data  = res_data_p1;
  assign bus.res_err   = res_err_p1;

`ifdef ALU_ISSUE_OPCNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (state_q == EXEC) begin
      op_count <= sat_inc16(op_count);
      if (exec_err) err_count <= sat_inc8(err_count);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;

  alu_issue_stage_if #(.WIDTH(8), .MUL_WIDTH(12)) bus ();

`ifdef ALU_ISSUE_OPCNT_EN
  logic [15:0] op_count;
  logic [7:0]  err_count;
`endif

  alu_issue_stage #(
    .WIDTH     (8),
    .MUL_WIDTH (12),
    .DEPTH     (4)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .bus       (bus)
`ifdef ALU_ISSUE_OPCNT_EN
    ,
    .op_count  (op_count),
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU. Illegal opcodes and b==0 divides return junk on purpose so
  // the stage must actively zero them.
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    logic [11:0] ea;
    logic [11:0] eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (op)
      4'd0:    return ea + eb;
      4'd1:    return ea - eb;
      4'd2:    return ea * eb;
      4'd3:    return ea >> b[2:0];
      4'd4:    return ea << b[2:0];
      4'd5:    return (b == 8'd0) ? 12'hFFF : ea / eb;
      4'd6:    return {4'b0, ~a};
      4'd7:    return ea & eb;
      4'd8:    return ea | eb;
      4'd9:    return ea ^ eb;
      4'd10:   return ea + 12'd1;
      default: return 12'hABC;
    endcase
  endfunction

  always_comb bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_opsel);

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [11:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  vec_t bp   [6];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [11:0] got_q   [$];
  int          got_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.res_valid && bus.res_ready) begin
      got_q.push_back(bus.res_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_phase();
    @(posedge clk);
    #1;
  endtask

  // One command through an idle stage with res_ready high; checks exact latency.
  task automatic run_vec(input int i);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = vecs[i].a;
    bus.cmd_b     = vecs[i].b;
    bus.cmd_opsel = vecs[i].op;
    @(negedge clk);
    chk($sformatf("vec%0d cmd_ready", i), 32'(bus.cmd_ready), 32'd1);
    drive_phase();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d valid@N", i), 32'(bus.res_valid), 32'd0);
    drive_phase();
    @(negedge clk);
    chk($sformatf("vec%0d alu_a", i), 32'(bus.alu_a), 32'(vecs[i].a));
    chk($sformatf("vec%0d alu_b", i), 32'(bus.alu_b), 32'(vecs[i].b));
    chk($sformatf("vec%0d alu_opsel", i), 32'(bus.alu_opsel), 32'(vecs[i].op));
    chk($sformatf("vec%0d valid@N+1", i), 32'(bus.res_valid), 32'd0);
    drive_phase();
    @(negedge clk);
    chk($sformatf("vec%0d valid@N+2", i), 32'(bus.res_valid), 32'd1);
    chk($sformatf("vec%0d data", i), 32'(bus.res_data), 32'(vecs[i].exp_data));
    chk($sformatf("vec%0d err", i), 32'(bus.res_err), 32'(vecs[i].exp_err));
    drive_phase();
    @(negedge clk);
    chk($sformatf("vec%0d valid@N+3", i), 32'(bus.res_valid), 32'd0);
    drive_phase();
  endtask

  task automatic push_now(input vec_t v);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    bus.cmd_opsel = v.op;
    drive_phase();
  endtask

  initial begin
    int n_err_exp;
    int budget;
    logic pending;

    vecs[0]  = '{8'd118,  8'd28,  4'd0,  12'd146,  1'b0};
    vecs[1]  = '{8'd98,   8'd0,   4'd5,  12'd0,    1'b1};
    vecs[2]  = '{8'd98,   8'd42,  4'd5,  12'd2,    1'b0};
    vecs[3]  = '{8'd5,    8'd5,   4'd12, 12'd0,    1'b1};
    vecs[4]  = '{8'd1,    8'd1,   4'd0,  12'd2,    1'b0};
    vecs[5]  = '{8'd5,    8'd7,   4'd1,  12'hFFE,  1'b0};
    vecs[6]  = '{8'd200,  8'd15,  4'd2,  12'd3000, 1'b0};
    vecs[7]  = '{8'hF0,   8'd4,   4'd3,  12'h00F,  1'b0};
    vecs[8]  = '{8'h81,   8'd3,   4'd4,  12'h408,  1'b0};
    vecs[9]  = '{8'h0F,   8'd0,   4'd6,  12'h0F0,  1'b0};
    vecs[10] = '{8'hCC,   8'hAA,  4'd7,  12'h088,  1'b0};
    vecs[11] = '{8'hCC,   8'hAA,  4'd8,  12'h0EE,  1'b0};
    vecs[12] = '{8'hCC,   8'hAA,  4'd9,  12'h066,  1'b0};
    vecs[13] = '{8'd255,  8'd0,   4'd10, 12'd256,  1'b0};
    vecs[14] = '{8'd3,    8'd9,   4'd15, 12'd0,    1'b1};

    bp[0] = '{8'd10,  8'd20,  4'd0, 12'd30,  1'b0};
    bp[1] = '{8'd50,  8'd8,   4'd1, 12'd42,  1'b0};
    bp[2] = '{8'd12,  8'd12,  4'd2, 12'd144, 1'b0};
    bp[3] = '{8'hFF,  8'h0F,  4'd9, 12'd240, 1'b0};
    bp[4] = '{8'd100, 8'd7,   4'd5, 12'd14,  1'b0};
    bp[5] = '{8'h30,  8'h03,  4'd8, 12'd51,  1'b0};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_opsel = '0;
    bus.res_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst res_data", 32'(bus.res_data), 32'd0);
    chk("rst res_err", 32'(bus.res_err), 32'd0);
    chk("rst alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst alu_opsel", 32'(bus.alu_opsel), 32'd0);
    drive_phase();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    drive_phase();

    // Reset while a command is executing with three more queued
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_now(bp[i]);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    drive_phase();
    bus.res_ready = 1'b0;
    chk("midrst pre alu_a", 32'(bus.alu_a), 32'(bp[1].a));
    chk("midrst pre valid", 32'(bus.res_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst res_valid", 32'(bus.res_valid), 32'd0);
    chk("midrst alu_a", 32'(bus.alu_a), 32'd0);
    chk("midrst alu_b", 32'(bus.alu_b), 32'd0);
    chk("midrst alu_opsel", 32'(bus.alu_opsel), 32'd0);
    chk("midrst res_data", 32'(bus.res_data), 32'd0);
    drive_phase();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    drive_phase();
    got_q.delete();
    got_cyc.delete();
    bus.res_ready = 1'b1;
    repeat (8) drive_phase();
    chk("midrst no stale result", 32'(got_q.size()), 32'd0);

    // Directed single-command vectors
    n_err_exp = 0;
    for (int i = 0; i < NV; i++) begin
      run_vec(i);
      if (vecs[i].exp_err) n_err_exp++;
    end

`ifdef ALU_ISSUE_OPCNT_EN
    chk("op_count", 32'(op_count), 32'(NV));
    chk("err_count", 32'(err_count), 32'(n_err_exp));
`endif

    // Backpressure: fill the FIFO behind a stalled result
    got_q.delete();
    got_cyc.delete();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = bp[i].a;
      bus.cmd_b     = bp[i].b;
      bus.cmd_opsel = bp[i].op;
      @(negedge clk);
      chk($sformatf("bp push%0d ready", i), 32'(bus.cmd_ready), 32'd1);
      drive_phase();
    end
    bus.cmd_a     = bp[5].a;
    bus.cmd_b     = bp[5].b;
    bus.cmd_opsel = bp[5].op;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp full%0d cmd_ready", k), 32'(bus.cmd_ready), 32'd0);
      chk($sformatf("bp stall%0d valid", k), 32'(bus.res_valid), 32'd1);
      chk($sformatf("bp stall%0d data", k), 32'(bus.res_data), 32'(bp[0].exp_data));
      drive_phase();
    end
    bus.res_ready = 1'b1;
    budget  = 60;
    pending = 1'b1;
    while ((got_q.size() < 6 || pending) && budget > 0) begin
      @(negedge clk);
      if (bus.cmd_valid && bus.cmd_ready) pending = 1'b0;
      drive_phase();
      if (!pending) bus.cmd_valid = 1'b0;
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL bp drain timeout: got %0d results, expected 6", got_q.size());
    end
    chk("bp result count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      chk($sformatf("bp result%0d", i), 32'(got_q[i]), 32'(bp[i].exp_data));
      if (i > 0)
        chk($sformatf("bp spacing%0d", i), 32'(got_cyc[i] - got_cyc[i-1] >= 2), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream command stage for the combinational ALU (a, b, opsel → result).
- Buffers operand/opcode commands from a producer in a small FIFO and issues one command at a time to the ALU through registered operand outputs.
- Captures the ALU result and presents it downstream with a valid/ready handshake.
- Flags illegal opcodes and divide-by-zero, so the ALU never has to.

Parameters:
- WIDTH, 8, operand width; drives ALU a/b.
- MUL_WIDTH, 12, ALU result width.
- DEPTH, 4, command FIFO depth; power of 2, ≥2.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  producer has a command.
- cmd_ready  out  1  FIFO not full.
- cmd_a  in  WIDTH  operand a.
- cmd_b  in  WIDTH  operand b.
- cmd_opsel  in  4  opcode.
- alu_a  out  WIDTH  registered operand to ALU.
- alu_b  out  WIDTH  registered operand to ALU.
- alu_opsel  out  4  registered opcode to ALU.
- alu_result  in  MUL_WIDTH  combinational ALU result.
- res_valid  out  1  res_data is valid.
- res_ready  in  1  consumer accepts.
- res_data  out  MUL_WIDTH  captured result.
- res_err  out  1  illegal opcode or divide-by-zero.

Behaviour:
- Reset (RST low, async): FIFO empty, FSM=IDLE, alu_a/alu_b/alu_opsel=0, res_valid=0, res_data=0, res_err=0, cmd_ready=1 after release.
- Command push: cmd_valid & cmd_ready at a rising edge writes the command. cmd_ready = !full (registered count, no combinational path from res_ready).
- Opcode map (shared package):
  - 0 ADD, 1 SUB, 2 MUL, 3 SHR, 4 SHL, 5 DIV, 6 NOT, 7 AND, 8 OR, 9 XOR, 10 INC.
  - 11–15 are illegal.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_opsel → EXEC.
  - EXEC (exactly one cycle):
    - Capture res_data = alu_result, res_err = 0 for legal ops.
    - Illegal opsel, or opsel=5 with alu_b=0: res_data = 0, res_err = 1.
    - Set res_valid = 1 → DONE.
  - DONE: hold res_data/res_err stable while res_valid & !res_ready. On res_ready:
    - res_valid drops.
    - If FIFO non-empty, pop the next command in the same edge → EXEC; else → IDLE.
- Latency: command accepted at edge N with FIFO empty and FSM IDLE → alu_* valid after N+1 → res_valid after N+2.
- Peak throughput: one result per 2 cycles.
- Simultaneous push and pop on the same edge: count unchanged; a push while full is ignored (cmd_ready already low). Pushing into an empty FIFO does not bypass; the pop occurs on the next edge.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits; full = (count == DEPTH).
- alu_* outputs retain the last issued command in DONE/IDLE (no glitching to 0).
- Reset mid-operation: in-flight and buffered commands are discarded; no partial result is emitted.

Optional Feature:
- Macro ALU_ISSUE_OPCNT_EN.
- Defined:
  - Adds output op_count [15:0], incremented on each EXEC cycle.
  - Saturates at 16'hFFFF.
  - Reset to 0.
  - Also adds output err_count [7:0], incremented on each EXEC with error, saturating.
- Undefined: ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_INC, OP_LAST=10) and FSM state encoding (IDLE=0, EXEC=1, DONE=2).
- Sub-module alu_cmd_fifo: synchronous FIFO with WIDTH*2+4-bit entries, DEPTH parameter, same CLK/RST, ports push/pop/full/empty/data.
- alu_issue_stage instantiates alu_cmd_fifo plus the FSM and output registers.

Test Plan:
- Single ADD: a=118, b=28, opsel=0, res_ready=1, ALU model connected → res_data=146, res_err=0, res_valid 2 cycles after acceptance, high for 1 cycle.
- Divide by zero: opsel=5, a=98, b=0 → res_data=0, res_err=1. Then opsel=5, a=98, b=42 → res_data=2, res_err=0.
- Illegal opcode: opsel=12, a=5, b=5 → res_data=0, res_err=1; a following ADD 1+1 → 2, res_err=0.
- Backpressure/full (DEPTH=4): res_ready=0, push 6 commands back-to-back:
  - First is issued, next 4 fill the FIFO.
  - cmd_ready=0 before the 6th; the 6th is held.
  - res_data stable while stalled.
  - Release res_ready → 6 results in push order, each res_valid pulse ≥2 cycles apart.
- Reset mid-operation: assert RST in EXEC with 3 commands queued → immediately res_valid=0, alu_*=0, cmd_ready=1 after release; no stale result appears.
- With ALU_ISSUE_OPCNT_EN: 5 legal + 2 error ops → op_count=7, err_count=2.
